// File: rtl/ball_ctrl.sv
// Pong ball motion controller: once per frame applies paddle/wall bounces,
// advances the ball with saturation, detects goals and sequences the serve.
module ball_ctrl #(
   parameter int unsigned S_WIDTH      = 640,
   parameter int unsigned S_HEIGHT     = 480,
   parameter int unsigned SPEED        = 2,
   parameter int unsigned SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame,
   input  logic       serve,
   input  logic       coll_v,
   input  logic       coll_h,
   input  logic       coll_p1,
   input  logic       coll_p2,
   output logic [9:0] bx,
   output logic [8:0] by,
   output logic       dir_x,
   output logic       dir_y,
   output logic       in_play,
   output logic       score_p1,
   output logic       score_p2
);

   localparam int unsigned X_W   = 10;
   localparam int unsigned Y_W   = 9;
   localparam int unsigned X_EW  = X_W + 1;
   localparam int unsigned Y_EW  = Y_W + 1;
   localparam int unsigned CNT_W = 8;

   localparam logic [X_W-1:0]   X_MID      = X_W'(S_WIDTH / 2);
   localparam logic [Y_W-1:0]   Y_MID      = Y_W'(S_HEIGHT / 2);
   localparam logic [X_W-1:0]   X_MAX      = X_W'(S_WIDTH - 1);
   localparam logic [Y_W-1:0]   Y_MAX      = Y_W'(S_HEIGHT - 1);
   localparam logic [X_EW-1:0]  X_MAX_EXT  = X_EW'(S_WIDTH - 1);
   localparam logic [Y_EW-1:0]  Y_MAX_EXT  = Y_EW'(S_HEIGHT - 1);
   localparam logic [X_W-1:0]   X_STEP     = X_W'(SPEED);
   localparam logic [Y_W-1:0]   Y_STEP     = Y_W'(SPEED);
   localparam logic [X_EW-1:0]  X_STEP_EXT = X_EW'(SPEED);
   localparam logic [Y_EW-1:0]  Y_STEP_EXT = Y_EW'(SPEED);
   localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(SERVE_FRAMES);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SERVE,
      ST_PLAY,
      ST_SCORED
   } state_e;

   state_e           state_q, state_d;
   logic [X_W-1:0]   bx_q, bx_d;
   logic [Y_W-1:0]   by_q, by_d;
   logic             dir_x_q, dir_x_d;
   logic             dir_y_q, dir_y_d;
   logic             in_play_q, in_play_d;
   logic             score_p1_q, score_p1_d;
   logic             score_p2_q, score_p2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [X_EW-1:0]  x_sum;
   logic [Y_EW-1:0]  y_sum;
   logic             goal;

   // Next-state and next-value logic; everything holds unless frame is high.
   always_comb begin
      state_d    = state_q;
      bx_d       = bx_q;
      by_d       = by_q;
      dir_x_d    = dir_x_q;
      dir_y_d    = dir_y_q;
      in_play_d  = in_play_q;
      cnt_d      = cnt_q;
      score_p1_d = 1'b0;
      score_p2_d = 1'b0;
      x_sum      = '0;
      y_sum      = '0;
      goal       = 1'b0;

      if (frame) begin
         unique case (state_q)
            ST_IDLE: begin
               bx_d = X_MID;
               by_d = Y_MID;
               if (serve) begin
                  cnt_d   = CNT_INIT;
                  state_d = ST_SERVE;
               end
            end

            ST_SERVE: begin
               bx_d = X_MID;
               by_d = Y_MID;
               if (cnt_q == CNT_LAST) state_d = ST_PLAY;
               else                   cnt_d   = cnt_q - CNT_LAST;
            end

            ST_PLAY: begin
               // Paddles force a direction; both at once leaves it alone.
               if (coll_p1 && !coll_p2)      dir_x_d = 1'b1;
               else if (coll_p2 && !coll_p1) dir_x_d = 1'b0;

               // Wall bounce points the ball back toward the screen middle.
               if (coll_v) dir_y_d = (by_q < Y_MID);

               goal = coll_h && !coll_p1 && !coll_p2;
               if (goal) begin
                  if (bx_q < X_MID) begin
                     score_p2_d = 1'b1;
                     dir_x_d    = 1'b0;
                  end else begin
                     score_p1_d = 1'b1;
                     dir_x_d    = 1'b1;
                  end
                  bx_d    = X_MID;
                  by_d    = Y_MID;
                  state_d = ST_SCORED;
               end else begin
                  x_sum = {1'b0, bx_q} + X_STEP_EXT;
                  y_sum = {1'b0, by_q} + Y_STEP_EXT;
                  if (dir_x_d) bx_d = (x_sum > X_MAX_EXT) ? X_MAX : x_sum[X_W-1:0];
                  else         bx_d = (bx_q < X_STEP) ? '0 : bx_q - X_STEP;
                  if (dir_y_d) by_d = (y_sum > Y_MAX_EXT) ? Y_MAX : y_sum[Y_W-1:0];
                  else         by_d = (by_q < Y_STEP) ? '0 : by_q - Y_STEP;
               end
            end

            ST_SCORED: begin
               bx_d    = X_MID;
               by_d    = Y_MID;
               cnt_d   = CNT_INIT;
               state_d = ST_SERVE;
            end

            default: state_d = ST_IDLE;
         endcase

         in_play_d = (state_d == ST_PLAY);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bx_q       <= X_MID;
         by_q       <= Y_MID;
         dir_x_q    <= 1'b1;
         dir_y_q    <= 1'b1;
         in_play_q  <= 1'b0;
         score_p1_q <= 1'b0;
         score_p2_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         bx_q       <= bx_d;
         by_q       <= by_d;
         dir_x_q    <= dir_x_d;
         dir_y_q    <= dir_y_d;
         in_play_q  <= in_play_d;
         score_p1_q <= score_p1_d;
         score_p2_q <= score_p2_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bx       = bx_q;
   assign by       = by_q;
   assign dir_x    = dir_x_q;
   assign dir_y    = dir_y_q;
   assign in_play  = in_play_q;
   assign score_p1 = score_p1_q;
   assign score_p2 = score_p2_q;

endmodule
